// File: rtl/evr_event_sequencer_pkg.sv
// Shared types for the event sequencer: FSM states, table entry layout, control
// bit positions and the status word packing.
package evr_event_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_WAIT,
    ST_EMIT
  } seq_state_t;

  localparam int CTL_RUN  = 31;
  localparam int CTL_LOOP = 30;
  localparam int CTL_CLR  = 29;

  typedef struct packed {
    logic [7:0]  code;
    logic [23:0] delay;
  } entry_t;

  function automatic logic [31:0] pack_status(
    input logic       running,
    input logic       loop_en,
    input logic       rejected,
    input logic [3:0] addr_width,
    input logic [7:0] pass_count,
    input logic [7:0] play_index,
    input logic [7:0] write_addr
  );
    return {running, loop_en, rejected, 1'b0, addr_width, pass_count, play_index, write_addr};
  endfunction

endpackage

// File: rtl/evr_event_sequencer_table.sv
// Event table RAM: one write port, one registered read port (1-cycle latency), no reset.
// No backpressure; contents survive reset.
module evr_event_sequencer_table
  import evr_event_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  entry_t                wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output entry_t                rd_data
);

  entry_t mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/evr_event_sequencer.sv
// Replays a software-loaded (code, delay) table as a single-cycle event stream, once or looping.
// Event k leaves d_k+3 cycles after event k-1; output has no backpressure.
module evr_event_sequencer
  import evr_event_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        evrClk,
  input  logic        evrRstN,
  input  logic        evrCsrStrobe,
  input  logic [31:0] evrGpioOut,
  input  logic        evrTableStrobe,
  input  logic [31:0] evrTableData,
  output logic [31:0] evrCsr,
  output logic        evrSeqDone,
  output logic        evrTVALID,
  output logic [7:0]  evrTDATA
);

  localparam logic [ADDR_WIDTH-1:0] IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  seq_state_t            state;
  logic [ADDR_WIDTH-1:0] play_index;
  logic [ADDR_WIDTH-1:0] last_index;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [ADDR_WIDTH-1:0] tbl_wr_addr;
  logic                  tbl_wr_en;
  logic                  clr_addr;
  logic                  loop_en;
  logic                  write_rejected;
  logic [23:0]           counter;
  logic [7:0]            code;
  logic [7:0]            pass_count;
  entry_t                rd_entry;
  logic                  unused_gpio;

  assign unused_gpio = ^evrGpioOut[CTL_CLR-1:ADDR_WIDTH];

  // Address clear takes effect before a same-cycle table write.
  assign clr_addr    = evrCsrStrobe && evrGpioOut[CTL_CLR];
  assign tbl_wr_en   = evrTableStrobe && (state == ST_IDLE);
  assign tbl_wr_addr = clr_addr ? '0 : write_addr;

  evr_event_sequencer_table #(.ADDR_WIDTH(ADDR_WIDTH)) u_table (
    .clk     (evrClk),
    .wr_en   (tbl_wr_en),
    .wr_addr (tbl_wr_addr),
    .wr_data (entry_t'(evrTableData)),
    .rd_addr (play_index),
    .rd_data (rd_entry)
  );

  always_ff @(posedge evrClk or negedge evrRstN) begin
    if (!evrRstN) begin
      state          <= ST_IDLE;
      play_index     <= '0;
      last_index     <= '0;
      write_addr     <= '0;
      loop_en        <= 1'b0;
      write_rejected <= 1'b0;
      counter        <= '0;
      code           <= '0;
      pass_count     <= '0;
      evrTVALID      <= 1'b0;
      evrTDATA       <= '0;
      evrSeqDone     <= 1'b0;
      evrCsr         <= pack_status(1'b0, 1'b0, 1'b0, 4'(ADDR_WIDTH), 8'd0, 8'd0, 8'd0);
    end else begin
      evrTVALID  <= 1'b0;
      evrTDATA   <= '0;
      evrSeqDone <= 1'b0;
      evrCsr     <= pack_status(state != ST_IDLE, loop_en, write_rejected, 4'(ADDR_WIDTH),
                                pass_count, 8'(play_index), 8'(write_addr));

      unique case (state)
        ST_IDLE:  ;
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          counter <= rd_entry.delay;
          code    <= rd_entry.code;
          state   <= (rd_entry.delay != 24'd0) ? ST_WAIT : ST_EMIT;
        end
        ST_WAIT: begin
          if (counter <= 24'd1) begin
            state <= ST_EMIT;
          end else begin
            counter <= counter - 24'd1;
          end
        end
        ST_EMIT: begin
          // A zero code is a silent slot: timing advances, nothing is emitted.
          evrTVALID <= (code != 8'd0);
          evrTDATA  <= code;
          if (play_index != last_index) begin
            play_index <= play_index + IDX_ONE;
            state      <= ST_FETCH;
          end else begin
            evrSeqDone <= 1'b1;
            pass_count <= pass_count + 8'd1;
            play_index <= '0;
            state      <= loop_en ? ST_FETCH : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (evrCsrStrobe) begin
        loop_en        <= evrGpioOut[CTL_LOOP];
        last_index     <= evrGpioOut[ADDR_WIDTH-1:0];
        write_rejected <= 1'b0;
        if (clr_addr) begin
          write_addr <= '0;
        end
        if (evrGpioOut[CTL_RUN]) begin
          play_index <= '0;
          state      <= ST_FETCH;
        end else begin
          state <= ST_IDLE;
        end
      end

      if (tbl_wr_en) begin
        write_addr <= tbl_wr_addr + IDX_ONE;
      end
      if (evrTableStrobe && (state != ST_IDLE)) begin
        write_rejected <= 1'b1;
      end
    end
  end

endmodule
